// File: rtl/key_dir_decoder_if.sv
// Scancode byte stream in, held-direction vector and event pulses out.
interface key_dir_decoder_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [3:0] btnstate;
    logic       start_pulse;
    logic       parse_err;

    modport master (
        output byte_data, byte_valid,
        input  btnstate, start_pulse, parse_err
    );

    modport slave (
        input  byte_data, byte_valid,
        output btnstate, start_pulse, parse_err
    );
endinterface

// File: rtl/key_dir_decoder.sv
// PS/2 scancode parser: tracks held direction keys (arrows/WASD),
// resolves opposite keys last-pressed-wins, and pulses on Enter make.
module key_dir_decoder #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter bit ENABLE_WASD    = 1'b1
) (
    input logic              clk,
    input logic              rst,
    key_dir_decoder_if.slave kb
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [3:0]    held_q, held_d;
    logic          pri_v_q, pri_v_d;
    logic          pri_h_q, pri_h_d;
    logic          ent_q, ent_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    btn_d;
    logic          start_d, err_d;
    logic          mk, brk, ext, enter;
    logic [3:0]    dir, dir_x, dir_n;
    logic          is_e0, is_f0, is_aa, is_ent;

    assign is_e0  = kb.byte_data == 8'hE0;
    assign is_f0  = kb.byte_data == 8'hF0;
    assign is_aa  = kb.byte_data == 8'hAA;
    assign is_ent = kb.byte_data == 8'h5A;

    // Both maps decoded from the byte alone; prefix context picks one.
    always_comb begin
        dir_x = 4'b0000;
        dir_n = 4'b0000;
        unique case (1'b1)
            kb.byte_data == 8'h75: dir_x = 4'b1000;
            kb.byte_data == 8'h72: dir_x = 4'b0100;
            kb.byte_data == 8'h6B: dir_x = 4'b0010;
            kb.byte_data == 8'h74: dir_x = 4'b0001;
            default:               dir_x = 4'b0000;
        endcase
        if (ENABLE_WASD) begin
            unique case (1'b1)
                kb.byte_data == 8'h1D: dir_n = 4'b1000;
                kb.byte_data == 8'h1B: dir_n = 4'b0100;
                kb.byte_data == 8'h1C: dir_n = 4'b0010;
                kb.byte_data == 8'h23: dir_n = 4'b0001;
                default:               dir_n = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        pri_v_d = pri_v_q;
        pri_h_d = pri_h_q;
        ent_d   = ent_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        start_d = 1'b0;
        mk      = 1'b0;
        brk     = 1'b0;
        ext     = 1'b0;
        if (kb.byte_valid) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (is_e0) begin
                        state_d = EXT;
                    end else if (is_f0) begin
                        state_d = BRK;
                    end else if (is_aa) begin
                        held_d = 4'b0000;
                        ent_d  = 1'b0;
                    end else begin
                        mk = 1'b1;
                    end
                end
                EXT: begin
                    if (is_f0) begin
                        state_d = EXT_BRK;
                    end else if (is_e0) begin
                        err_d = 1'b1;
                    end else begin
                        mk      = 1'b1;
                        ext     = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_d = IDLE;
                    if (is_e0 || is_f0) begin
                        err_d = 1'b1;
                    end else begin
                        brk = 1'b1;
                        ext = (state_q == EXT_BRK);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        dir   = ext ? dir_x : dir_n;
        enter = !ext && is_ent;
        if (mk) begin
            held_d = held_q | dir;
            if (dir[3]) pri_v_d = 1'b1;
            if (dir[2]) pri_v_d = 1'b0;
            if (dir[1]) pri_h_d = 1'b1;
            if (dir[0]) pri_h_d = 1'b0;
            if (enter) begin
                start_d = !ent_q;
                ent_d   = 1'b1;
            end
        end
        if (brk) begin
            held_d = held_q & ~dir;
            if (enter) ent_d = 1'b0;
        end

        // pri_v: 1 = up pressed last; pri_h: 1 = left pressed last
        btn_d[3] = held_d[3] & (~held_d[2] |  pri_v_d);
        btn_d[2] = held_d[2] & (~held_d[3] | ~pri_v_d);
        btn_d[1] = held_d[1] & (~held_d[0] |  pri_h_d);
        btn_d[0] = held_d[0] & (~held_d[1] | ~pri_h_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            held_q         <= 4'b0000;
            pri_v_q        <= 1'b0;
            pri_h_q        <= 1'b0;
            ent_q          <= 1'b0;
            cnt_q          <= '0;
            kb.btnstate    <= 4'b0000;
            kb.start_pulse <= 1'b0;
            kb.parse_err   <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_q         <= held_d;
            pri_v_q        <= pri_v_d;
            pri_h_q        <= pri_h_d;
            ent_q          <= ent_d;
            cnt_q          <= cnt_d;
            kb.btnstate    <= btn_d;
            kb.start_pulse <= start_d;
            kb.parse_err   <= err_d;
        end
    end
endmodule
